// File: rtl/placement_cost_eval.sv
// placement_cost_eval: walks the edge list and node position memories after
// placement and accumulates Manhattan, 1-hop and Chebyshev wirelength costs.
// Each edge costs 8 cycles: RD_E..ACC. Memory reads are registered and the
// returned data is consumed two states after the issuing RD_* state.
module placement_cost_eval #(
    parameter int unsigned N_EDGE = 22,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              edge_re,
    output logic [ADDR_W-1:0] edge_addr,
    input  logic [DATA_W-1:0] edge_a,
    input  logic [DATA_W-1:0] edge_b,
    output logic              pos_re,
    output logic [ADDR_W-1:0] pos_addr,
    input  logic [DATA_W-1:0] pos_x,
    input  logic [DATA_W-1:0] pos_y,
    output logic [DATA_W-1:0] cost_man,
    output logic [DATA_W-1:0] cost_1hop,
    output logic [DATA_W-1:0] cost_cheb,
    output logic              unplaced
);

    typedef enum logic [3:0] {
        IDLE, RD_E, WT_E, RD_A, WT_A, RD_B, WT_B, CALC, ACC, FIN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_EDGE = (N_EDGE == 0) ? '0 : ADDR_W'(N_EDGE - 1);
    localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);
    localparam logic [DATA_W-1:0] D_ONE     = DATA_W'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_b;
    logic [DATA_W-1:0] r_xa;
    logic [DATA_W-1:0] r_ya;
    logic [DATA_W-1:0] r_xb;
    logic [DATA_W-1:0] r_dx;
    logic [DATA_W-1:0] r_dy;

    logic              r_busy;
    logic              r_done;
    logic              r_edge_re;
    logic [ADDR_W-1:0] r_edge_addr;
    logic              r_pos_re;
    logic [ADDR_W-1:0] r_pos_addr;
    logic [DATA_W-1:0] r_cost_man;
    logic [DATA_W-1:0] r_cost_1hop;
    logic [DATA_W-1:0] r_cost_cheb;
    logic              r_unplaced;

    logic [DATA_W-1:0] w_ddx;
    logic [DATA_W-1:0] w_ddy;
    logic [DATA_W-1:0] w_adx;
    logic [DATA_W-1:0] w_ady;
    logic [DATA_W-1:0] w_man;
    logic [DATA_W-1:0] w_hop;
    logic [DATA_W-1:0] w_cheb;
    logic              w_skip;

    // Absolute coordinate differences (B's position arrives on pos_x/pos_y in CALC)
    // and the three per-edge cost terms derived from the latched distances.
    always_comb begin
        w_ddx  = r_xa - pos_x;
        w_ddy  = r_ya - pos_y;
        w_adx  = w_ddx[DATA_W-1] ? -w_ddx : w_ddx;
        w_ady  = w_ddy[DATA_W-1] ? -w_ddy : w_ddy;
        w_man  = r_dx + r_dy - D_ONE;
        w_hop  = (r_dx >> 1) + DATA_W'(r_dx[0]) + (r_dy >> 1) + DATA_W'(r_dy[0]) - D_ONE;
        w_cheb = ((r_dx > r_dy) ? r_dx : r_dy) - D_ONE;
        w_skip = (r_xa == '1) || (r_xb == '1);
    end

    // Controller: sequences memory reads per edge, accumulates costs, and
    // drives all handshake and memory-interface outputs from registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_b         <= '0;
            r_xa        <= '0;
            r_ya        <= '0;
            r_xb        <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_edge_re   <= 1'b0;
            r_edge_addr <= '0;
            r_pos_re    <= 1'b0;
            r_pos_addr  <= '0;
            r_cost_man  <= '0;
            r_cost_1hop <= '0;
            r_cost_cheb <= '0;
            r_unplaced  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_edge_re <= 1'b0;
            r_pos_re  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cost_man  <= '0;
                        r_cost_1hop <= '0;
                        r_cost_cheb <= '0;
                        r_unplaced  <= 1'b0;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= (N_EDGE == 0) ? FIN : RD_E;
                    end
                end
                RD_E: begin
                    r_edge_re   <= 1'b1;
                    r_edge_addr <= r_cnt;
                    r_state     <= WT_E;
                end
                WT_E: r_state <= RD_A;
                RD_A: begin
                    r_b        <= ADDR_W'(edge_b);
                    r_pos_re   <= 1'b1;
                    r_pos_addr <= ADDR_W'(edge_a);
                    r_state    <= WT_A;
                end
                WT_A: r_state <= RD_B;
                RD_B: begin
                    r_xa       <= pos_x;
                    r_ya       <= pos_y;
                    r_pos_re   <= 1'b1;
                    r_pos_addr <= r_b;
                    r_state    <= WT_B;
                end
                WT_B: r_state <= CALC;
                CALC: begin
                    r_xb    <= pos_x;
                    r_dx    <= w_adx;
                    r_dy    <= w_ady;
                    r_state <= ACC;
                end
                ACC: begin
                    if (w_skip) begin
                        r_unplaced <= 1'b1;
                    end else begin
                        r_cost_man  <= r_cost_man + w_man;
                        r_cost_1hop <= r_cost_1hop + w_hop;
                        r_cost_cheb <= r_cost_cheb + w_cheb;
                    end
                    r_cnt   <= r_cnt + A_ONE;
                    r_state <= (r_cnt == LAST_EDGE) ? FIN : RD_E;
                end
                FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign edge_re   = r_edge_re;
    assign edge_addr = r_edge_addr;
    assign pos_re    = r_pos_re;
    assign pos_addr  = r_pos_addr;
    assign cost_man  = r_cost_man;
    assign cost_1hop = r_cost_1hop;
    assign cost_cheb = r_cost_cheb;
    assign unplaced  = r_unplaced;

endmodule

// File: tb/tb_placement_cost_eval.sv
// Bench for placement_cost_eval with N_EDGE=3: memory models, a cycle-level
// reference derived from the pass timeline, and directed passes with
// hand-computed cost literals.
module tb_placement_cost_eval;

    localparam int NE = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, edge_re, pos_re, unplaced;
    logic [31:0] edge_addr, pos_addr, cost_man, cost_1hop, cost_cheb;
    logic [31:0] edge_a, edge_b, pos_x, pos_y;

    int total = 0;
    int bad   = 0;

    int ea[NE];
    int eb[NE];
    int px[8];
    int py[8];

    placement_cost_eval #(
        .N_EDGE(NE),
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .busy(busy),
        .done(done),
        .edge_re(edge_re),
        .edge_addr(edge_addr),
        .edge_a(edge_a),
        .edge_b(edge_b),
        .pos_re(pos_re),
        .pos_addr(pos_addr),
        .pos_x(pos_x),
        .pos_y(pos_y),
        .cost_man(cost_man),
        .cost_1hop(cost_1hop),
        .cost_cheb(cost_cheb),
        .unplaced(unplaced)
    );

    always #5 clk = ~clk;

    // Synchronous ROM/RAM models: read sampled on the edge, data held until next read.
    always @(posedge clk) begin
        if (edge_re) begin
            edge_a <= (edge_addr < NE) ? ea[edge_addr[1:0]] : 0;
            edge_b <= (edge_addr < NE) ? eb[edge_addr[1:0]] : 0;
        end
        if (pos_re) begin
            pos_x <= (pos_addr < 8) ? px[pos_addr[2:0]] : 0;
            pos_y <= (pos_addr < 8) ? py[pos_addr[2:0]] : 0;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference state: mj counts edges since the start was accepted (-1 = idle).
    int mj = -1;
    int ecm = 0, ech = 0, ecc = 0;
    int eun = 0, mdone = 0, eere = 0, epre = 0, eea = 0, epa = 0;

    task automatic add_edge(input int k);
        int a, b, dx, dy;
        a = ea[k];
        b = eb[k];
        if (px[a] == -1 || px[b] == -1) begin
            eun = 1;
        end else begin
            dx  = iabs(px[a] - px[b]);
            dy  = iabs(py[a] - py[b]);
            ecm = ecm + dx + dy - 1;
            ech = ech + (dx + 1) / 2 + (dy + 1) / 2 - 1;
            ecc = ecc + ((dx > dy) ? dx : dy) - 1;
        end
    endtask

    // Compare process: advance the reference by one edge, then check every output.
    always @(negedge clk) begin
        mdone = 0;
        eere  = 0;
        epre  = 0;
        if (reset) begin
            mj = -1; ecm = 0; ech = 0; ecc = 0; eun = 0; eea = 0; epa = 0;
        end else if (mj >= 0) begin
            mj++;
            if (mj == 8 * NE + 1) begin
                mj    = -1;
                mdone = 1;
            end else if (mj % 8 == 0) begin
                add_edge(mj / 8 - 1);
            end else if (mj % 8 == 1) begin
                eere = 1;
                eea  = mj / 8;
            end else if (mj % 8 == 3) begin
                epre = 1;
                epa  = ea[mj / 8];
            end else if (mj % 8 == 5) begin
                epre = 1;
                epa  = eb[mj / 8];
            end
        end else if (start) begin
            mj = 0; ecm = 0; ech = 0; ecc = 0; eun = 0;
        end
        chk("busy", int'(busy), (mj >= 0) ? 1 : 0);
        chk("done", int'(done), mdone);
        chk("edge_re", int'(edge_re), eere);
        chk("edge_addr", int'(edge_addr), eea);
        chk("pos_re", int'(pos_re), epre);
        chk("pos_addr", int'(pos_addr), epa);
        chk("cost_man", int'(cost_man), ecm);
        chk("cost_1hop", int'(cost_1hop), ech);
        chk("cost_cheb", int'(cost_cheb), ecc);
        chk("unplaced", int'(unplaced), eun);
    end

    task automatic lit(input string nm, input int m, input int h, input int c, input int u);
        chk({nm, "_man"}, int'(cost_man), m);
        chk({nm, "_1hop"}, int'(cost_1hop), h);
        chk({nm, "_cheb"}, int'(cost_cheb), c);
        chk({nm, "_unplaced"}, int'(unplaced), u);
    endtask

    // One pass: start sampled at edge 0; lat = edge index at which done is sampled high.
    task automatic run_pass(input int dup_at, input int rst_at, output int lat);
        @(negedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (done && lat < 0) lat = n + 1;
            if (n == rst_at + 1) begin
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_edge_addr", int'(edge_addr), 0);
                chk("rst_pos_addr", int'(pos_addr), 0);
                lit("rst", 0, 0, 0, 0);
            end
            #1;
            start = (n == dup_at);
            reset = (n == rst_at);
            if (lat >= 0) break;
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic load_a();
        ea[0] = 0; eb[0] = 1;
        ea[1] = 1; eb[1] = 2;
        ea[2] = 0; eb[2] = 2;
        for (int i = 0; i < 8; i++) begin
            px[i] = 0;
            py[i] = 0;
        end
        px[1] = 0; py[1] = 3;
        px[2] = 2; py[2] = 1;
    endtask

    int lat;

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_edge_re", int'(edge_re), 0);
        chk("reset_pos_re", int'(pos_re), 0);
        lit("reset", 0, 0, 0, 0);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic 3-edge triangle.
        load_a();
        run_pass(-1, -1, lat);
        chk("basic_latency", lat, 26);
        lit("basic", 7, 3, 4, 0);

        // Node 1 unplaced: only edge 0-2 contributes.
        load_a();
        px[1] = -1;
        run_pass(-1, -1, lat);
        chk("unpl_latency", lat, 26);
        lit("unpl", 2, 1, 1, 1);

        // Zero-length third edge between two nodes at (4,4).
        load_a();
        ea[2] = 3; eb[2] = 4;
        px[3] = 4; py[3] = 4;
        px[4] = 4; py[4] = 4;
        run_pass(-1, -1, lat);
        lit("zero", 4, 1, 2, 0);

        // Negative coordinates exercise the absolute-value path.
        load_a();
        ea[0] = 5; eb[0] = 6;
        ea[1] = 6; eb[1] = 7;
        ea[2] = 7; eb[2] = 0;
        px[5] = -3; py[5] = 2;
        px[6] = 5;  py[6] = -4;
        px[7] = 1;  py[7] = -2;
        run_pass(-1, -1, lat);
        lit("neg", 20, 9, 11, 0);

        // Start pulsed mid-pass is ignored.
        load_a();
        run_pass(10, -1, lat);
        chk("dup_latency", lat, 26);
        lit("dup", 7, 3, 4, 0);

        // Start sampled during FIN is ignored: stays idle afterwards.
        run_pass(24, -1, lat);
        chk("fin_latency", lat, 26);
        repeat (3) @(negedge clk);
        chk("fin_idle_busy", int'(busy), 0);
        lit("fin", 7, 3, 4, 0);

        // Reset sampled while in WT_A of edge 1 aborts without done.
        run_pass(-1, 11, lat);
        chk("abort_no_done", lat, -1);
        run_pass(-1, -1, lat);
        chk("after_abort_latency", lat, 26);
        lit("after_abort", 7, 3, 4, 0);

        // Back-to-back passes: costs recomputed, not doubled.
        run_pass(-1, -1, lat);
        lit("b2b_first", 7, 3, 4, 0);
        run_pass(-1, -1, lat);
        chk("b2b_latency", lat, 26);
        lit("b2b_second", 7, 3, 4, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
